// File: rtl/demux16_pkg.sv
// Shared channel-count constants, select/mask types and the one-hot decode helper
// for the 16-channel scanning demultiplexer.
package demux16_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef logic [SEL_W-1:0]  ch_sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  localparam ch_sel_t LAST_CH = ch_sel_t'(NUM_CH - 1);

  function automatic ch_mask_t ch_onehot(input ch_sel_t s);
    ch_onehot = ch_mask_t'(1) << s;
  endfunction

endpackage

// File: rtl/demux16_channel.sv
// One demux channel: a shadow register filled by auto-scan writes and a visible
// register loaded either directly or from the shadow at frame publish.
module demux16_channel #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_wr_vis,
  input  logic             i_wr_shadow,
  input  logic             i_publish,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_value,
  output logic             o_changed
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  logic [WIDTH-1:0] w_pub_src;

  // At publish, the channel being written in the same cycle takes the live data.
  assign w_pub_src = i_wr_shadow ? i_data : r_shadow;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_shadow  <= '0;
      r_value   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (i_wr_vis) begin
        // Direct writes also refresh the shadow so a later publish keeps this value.
        r_value   <= i_data;
        r_shadow  <= i_data;
        r_changed <= 1'b1;
      end else begin
        if (i_wr_shadow) r_shadow <= i_data;
        if (i_publish) begin
          r_value   <= w_pub_src;
          r_changed <= (w_pub_src != r_value);
        end
      end
    end
  end

  assign o_value   = r_value;
  assign o_changed = r_changed;

endmodule

// File: rtl/demux16_scan.sv
// Registered 1-to-16 demultiplexer with direct (sel) or auto-scan (ptr) targeting
// and optional per-frame double-buffering of auto-scan writes.
module demux16_scan
  import demux16_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter bit BUFFERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  ch_sel_t          sel,
  input  logic             load,
  input  logic             auto,
  input  logic             clear,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output ch_mask_t         strobe,
  output ch_sel_t          ptr,
  output logic             frame_done
);

  ch_sel_t          r_ptr;
  logic             r_frame_done;
  logic             w_clr;
  logic             w_auto_wr;
  logic             w_direct;
  logic             w_publish;
  ch_mask_t         w_dec;
  ch_mask_t         w_changed;
  logic [WIDTH-1:0] w_val [NUM_CH];

  // Reset and clear are the same synchronous wipe; both override any write.
  assign w_clr     = !rst_n || clear;
  assign w_auto_wr = load && auto;
  assign w_direct  = !auto || !BUFFERED;
  assign w_publish = w_auto_wr && BUFFERED && (r_ptr == LAST_CH);
  assign w_dec     = ch_onehot(auto ? r_ptr : sel);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    demux16_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .i_clear    (w_clr),
      .i_wr_vis   (load && w_direct && w_dec[n]),
      .i_wr_shadow(w_auto_wr && BUFFERED && w_dec[n]),
      .i_publish  (w_publish),
      .i_data     (in),
      .o_value    (w_val[n]),
      .o_changed  (w_changed[n])
    );
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ptr        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_auto_wr && (r_ptr == LAST_CH);
      if (w_auto_wr) r_ptr <= ch_sel_t'(r_ptr + 1'b1);
    end
  end

  assign strobe     = w_changed;
  assign ptr        = r_ptr;
  assign frame_done = r_frame_done;

  assign out0  = w_val[0];
  assign out1  = w_val[1];
  assign out2  = w_val[2];
  assign out3  = w_val[3];
  assign out4  = w_val[4];
  assign out5  = w_val[5];
  assign out6  = w_val[6];
  assign out7  = w_val[7];
  assign out8  = w_val[8];
  assign out9  = w_val[9];
  assign out10 = w_val[10];
  assign out11 = w_val[11];
  assign out12 = w_val[12];
  assign out13 = w_val[13];
  assign out14 = w_val[14];
  assign out15 = w_val[15];

endmodule

// File: tb/tb_demux16_scan.sv
// Directed bench for demux16_scan: a buffered and an unbuffered instance share
// the same stimulus; each scenario task checks the instance it targets.
module tb_demux16_scan;

  logic        clk = 1'b0;
  logic        rst_n, load, auto, clear;
  logic [3:0]  sel, in_d;
  logic [3:0]  b_out [16];
  logic [3:0]  d_out [16];
  logic [15:0] b_strobe, d_strobe;
  logic [3:0]  b_ptr, d_ptr;
  logic        b_fd, d_fd;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  demux16_scan #(.WIDTH(4), .BUFFERED(1'b1)) u_buf (
    .clk(clk), .rst_n(rst_n), .in(in_d), .sel(sel), .load(load), .auto(auto), .clear(clear),
    .out0(b_out[0]), .out1(b_out[1]), .out2(b_out[2]), .out3(b_out[3]),
    .out4(b_out[4]), .out5(b_out[5]), .out6(b_out[6]), .out7(b_out[7]),
    .out8(b_out[8]), .out9(b_out[9]), .out10(b_out[10]), .out11(b_out[11]),
    .out12(b_out[12]), .out13(b_out[13]), .out14(b_out[14]), .out15(b_out[15]),
    .strobe(b_strobe), .ptr(b_ptr), .frame_done(b_fd)
  );

  demux16_scan #(.WIDTH(4), .BUFFERED(1'b0)) u_dir (
    .clk(clk), .rst_n(rst_n), .in(in_d), .sel(sel), .load(load), .auto(auto), .clear(clear),
    .out0(d_out[0]), .out1(d_out[1]), .out2(d_out[2]), .out3(d_out[3]),
    .out4(d_out[4]), .out5(d_out[5]), .out6(d_out[6]), .out7(d_out[7]),
    .out8(d_out[8]), .out9(d_out[9]), .out10(d_out[10]), .out11(d_out[11]),
    .out12(d_out[12]), .out13(d_out[13]), .out14(d_out[14]), .out15(d_out[15]),
    .strobe(d_strobe), .ptr(d_ptr), .frame_done(d_fd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load  = 1'b0;
    auto  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    idle();
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    apply_reset(2);
    for (int ch = 0; ch < 16; ch++) begin
      checks++;
      if (b_out[ch] !== 4'h0 || d_out[ch] !== 4'h0) begin
        failures++;
        $display("FAIL reset_out ch=%0d got buf=%h dir=%h exp=0", ch, b_out[ch], d_out[ch]);
      end
    end
    checks++;
    if (b_strobe !== 16'h0 || d_strobe !== 16'h0 || b_ptr !== 4'h0 || d_ptr !== 4'h0
        || b_fd !== 1'b0 || d_fd !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got strobe=%h/%h ptr=%h/%h fd=%b/%b exp all 0",
               b_strobe, d_strobe, b_ptr, d_ptr, b_fd, d_fd);
    end
    load = 1'b1; auto = 1'b0; sel = 4'd5; in_d = 4'd1;
    step();
    load = 1'b0;
    for (int ch = 0; ch < 16; ch++) begin
      exp = (ch == 5) ? 4'd1 : 4'd0;
      checks++;
      if (b_out[ch] !== exp || d_out[ch] !== exp) begin
        failures++;
        $display("FAIL manual_out ch=%0d got buf=%h dir=%h exp=%h", ch, b_out[ch], d_out[ch], exp);
      end
    end
    checks++;
    if (b_strobe !== 16'h0020 || d_strobe !== 16'h0020) begin
      failures++;
      $display("FAIL manual_strobe got buf=%h dir=%h exp=0020", b_strobe, d_strobe);
    end
    checks++;
    if (b_ptr !== 4'h0 || d_ptr !== 4'h0) begin
      failures++;
      $display("FAIL manual_ptr got buf=%h dir=%h exp=0", b_ptr, d_ptr);
    end
    step();
    checks++;
    if (b_strobe !== 16'h0 || d_strobe !== 16'h0 || b_out[5] !== 4'd1) begin
      failures++;
      $display("FAIL manual_hold got strobe=%h/%h out5=%h exp strobe=0 out5=1",
               b_strobe, d_strobe, b_out[5]);
    end
  endtask

  task automatic test_buffered_frame();
    apply_reset(1);
    load = 1'b1; auto = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_d = i[3:0];
      step();
      if (i < 15) begin
        for (int ch = 0; ch < 16; ch++) begin
          checks++;
          if (b_out[ch] !== 4'h0) begin
            failures++;
            $display("FAIL buf_hold load=%0d ch=%0d got=%h exp=0", i, ch, b_out[ch]);
          end
        end
        checks++;
        if (b_strobe !== 16'h0 || b_fd !== 1'b0 || b_ptr !== 4'(i + 1)) begin
          failures++;
          $display("FAIL buf_ctrl load=%0d got strobe=%h fd=%b ptr=%h exp strobe=0 fd=0 ptr=%0d",
                   i, b_strobe, b_fd, b_ptr, i + 1);
        end
      end
    end
    load = 1'b0;
    for (int ch = 0; ch < 16; ch++) begin
      checks++;
      if (b_out[ch] !== 4'(ch)) begin
        failures++;
        $display("FAIL buf_publish ch=%0d got=%h exp=%h", ch, b_out[ch], 4'(ch));
      end
    end
    checks++;
    if (b_strobe !== 16'hFFFE || b_fd !== 1'b1 || b_ptr !== 4'h0) begin
      failures++;
      $display("FAIL buf_publish_ctrl got strobe=%h fd=%b ptr=%h exp strobe=fffe fd=1 ptr=0",
               b_strobe, b_fd, b_ptr);
    end
    step();
    checks++;
    if (b_strobe !== 16'h0 || b_fd !== 1'b0 || b_out[9] !== 4'd9) begin
      failures++;
      $display("FAIL buf_after got strobe=%h fd=%b out9=%h exp strobe=0 fd=0 out9=9",
               b_strobe, b_fd, b_out[9]);
    end
  endtask

  task automatic test_unbuffered_wrap();
    int         fd_count;
    logic [15:0] m;
    fd_count = 0;
    apply_reset(1);
    load = 1'b1; auto = 1'b1; in_d = 4'd1;
    for (int k = 0; k < 17; k++) begin
      step();
      m = 16'h1 << (k % 16);
      if (d_fd === 1'b1) fd_count++;
      checks++;
      if (d_strobe !== m || d_fd !== (k == 15)) begin
        failures++;
        $display("FAIL dir_walk load=%0d got strobe=%h fd=%b exp strobe=%h fd=%b",
                 k, d_strobe, d_fd, m, (k == 15));
      end
    end
    load = 1'b0;
    checks++;
    if (fd_count != 1 || d_ptr !== 4'd1) begin
      failures++;
      $display("FAIL dir_end got fd_pulses=%0d ptr=%h exp fd_pulses=1 ptr=1", fd_count, d_ptr);
    end
    for (int ch = 0; ch < 16; ch++) begin
      checks++;
      if (d_out[ch] !== 4'd1) begin
        failures++;
        $display("FAIL dir_out ch=%0d got=%h exp=1", ch, d_out[ch]);
      end
    end
  endtask

  task automatic test_clear_collision();
    apply_reset(1);
    load = 1'b1; auto = 1'b1; in_d = 4'd3;
    repeat (7) step();
    checks++;
    if (d_ptr !== 4'd7 || b_ptr !== 4'd7 || d_out[0] !== 4'd3) begin
      failures++;
      $display("FAIL clr_setup got ptr=%h/%h out0=%h exp ptr=7 out0=3", b_ptr, d_ptr, d_out[0]);
    end
    clear = 1'b1; in_d = 4'd5;
    step();
    clear = 1'b0; load = 1'b0;
    for (int ch = 0; ch < 16; ch++) begin
      checks++;
      if (b_out[ch] !== 4'h0 || d_out[ch] !== 4'h0) begin
        failures++;
        $display("FAIL clr_out ch=%0d got buf=%h dir=%h exp=0", ch, b_out[ch], d_out[ch]);
      end
    end
    checks++;
    if (b_ptr !== 4'h0 || d_ptr !== 4'h0 || b_strobe !== 16'h0 || d_strobe !== 16'h0
        || b_fd !== 1'b0 || d_fd !== 1'b0) begin
      failures++;
      $display("FAIL clr_ctrl got ptr=%h/%h strobe=%h/%h fd=%b/%b exp all 0",
               b_ptr, d_ptr, b_strobe, d_strobe, b_fd, d_fd);
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp;
    apply_reset(1);
    load = 1'b1; auto = 1'b1; in_d = 4'd2;
    repeat (4) step();
    auto = 1'b0; sel = 4'd10; in_d = 4'd1;
    step();
    checks++;
    if (b_out[10] !== 4'd1 || b_strobe !== 16'h0400 || b_ptr !== 4'd4) begin
      failures++;
      $display("FAIL sw_manual got out10=%h strobe=%h ptr=%h exp out10=1 strobe=0400 ptr=4",
               b_out[10], b_strobe, b_ptr);
    end
    auto = 1'b1; in_d = 4'd0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (j == 0) begin
        checks++;
        if (b_ptr !== 4'd5 || b_strobe !== 16'h0) begin
          failures++;
          $display("FAIL sw_resume got ptr=%h strobe=%h exp ptr=5 strobe=0", b_ptr, b_strobe);
        end
      end
      if (j < 11) begin
        checks++;
        if (b_out[10] !== 4'd1) begin
          failures++;
          $display("FAIL sw_hold load=%0d got out10=%h exp=1", j, b_out[10]);
        end
      end
    end
    load = 1'b0;
    for (int ch = 0; ch < 16; ch++) begin
      exp = (ch < 4) ? 4'd2 : 4'd0;
      checks++;
      if (b_out[ch] !== exp) begin
        failures++;
        $display("FAIL sw_publish ch=%0d got=%h exp=%h", ch, b_out[ch], exp);
      end
    end
    checks++;
    if (b_strobe !== 16'h040F || b_fd !== 1'b1 || b_ptr !== 4'h0) begin
      failures++;
      $display("FAIL sw_publish_ctrl got strobe=%h fd=%b ptr=%h exp strobe=040f fd=1 ptr=0",
               b_strobe, b_fd, b_ptr);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(1);
    load = 1'b1; auto = 1'b1; in_d = 4'd9;
    repeat (8) step();
    checks++;
    if (b_ptr !== 4'd8) begin
      failures++;
      $display("FAIL rmf_setup got ptr=%h exp=8", b_ptr);
    end
    apply_reset(1);
    checks++;
    if (b_ptr !== 4'h0) begin
      failures++;
      $display("FAIL rmf_ptr got=%h exp=0", b_ptr);
    end
    load = 1'b1; auto = 1'b1; in_d = 4'd0;
    repeat (16) step();
    load = 1'b0;
    checks++;
    if (b_strobe !== 16'h0 || b_fd !== 1'b1 || b_ptr !== 4'h0) begin
      failures++;
      $display("FAIL rmf_frame got strobe=%h fd=%b ptr=%h exp strobe=0 fd=1 ptr=0",
               b_strobe, b_fd, b_ptr);
    end
    for (int ch = 0; ch < 16; ch++) begin
      checks++;
      if (b_out[ch] !== 4'h0) begin
        failures++;
        $display("FAIL rmf_out ch=%0d got=%h exp=0", ch, b_out[ch]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 4'd0;
    in_d  = 4'd0;
    idle();
    test_reset();
    test_buffered_frame();
    test_unbuffered_wrap();
    test_clear_collision();
    test_mode_switch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux16_scan.md
# demux16_scan

Registered 1-to-16 demultiplexer with an auto-scan pointer and optional frame double-buffering. It is the write-side counterpart of the 16:1 output selector. A single data stream is distributed into sixteen held channel registers, either addressed directly by `sel` or sequentially by an internal pointer. Downstream logic, such as display columns or per-channel latches, sees stable outputs that change only on defined edges.

## Interface
- `WIDTH`, 1, data width of the input and of each channel.
- `BUFFERED`, 1, 1 = auto-mode writes fill a shadow bank that is published atomically per frame; 0 = auto-mode writes go directly to the outputs.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in`  input  WIDTH  data to store.
- `sel`  input  4  target channel in manual mode.
- `load`  input  1  write strobe; one write per cycle while high.
- `auto`  input  1  1 = target is `ptr`, `sel` ignored.
- `clear`  input  1  synchronous clear of all channels and the pointer.
- `out0`..`out15`  output  WIDTH each  visible channel registers.
- `strobe`  output  16  one-cycle pulse, bit n high in the cycle after `outn` changed due to a write.
- `ptr`  output  4  current auto-scan pointer.
- `frame_done`  output  1  one-cycle pulse after an auto write to channel 15.

## Operation
- Priority per cycle: `rst_n`=0, then `clear`, then `load`.
- Reset and clear have the same effect:
  - all `outn`, shadow registers, `ptr`, `strobe` and `frame_done` go to 0.
  - `clear` with `load` in the same cycle: the write is dropped and no strobe is issued.
- Manual write (`load`=1, `auto`=0):
  - `out[sel]` <= `in`.
  - The shadow copy of `sel` is also updated, so a later publish does not revert it.
  - `strobe[sel]` pulses.
  - `ptr` is unchanged.
- Auto write (`load`=1, `auto`=1):
  - Target is channel `ptr`.
  - `ptr` <= `ptr`+1 modulo 16, so 15 wraps to 0.
- Auto write with `BUFFERED`=0:
  - `out[ptr]` <= `in`.
  - `strobe[ptr]` pulses.
- Auto write with `BUFFERED`=1, `ptr`<15:
  - `shadow[ptr]` <= `in`.
  - Outputs are unchanged and no strobe is issued.
- Auto write with `BUFFERED`=1, `ptr`=15 (publish):
  - All outputs load from the shadow bank, with channel 15 taking `in` directly.
  - `strobe` is set to the bit mask of the channels whose value actually changed.
- `frame_done` pulses on every auto write to channel 15, in both buffered and unbuffered mode.
- Deasserting `auto` mid-frame:
  - `ptr` and the shadow contents are held.
  - A later return to auto resumes at `ptr`.
- `load`=0: no state change except that `strobe` and `frame_done` return to 0.
- Arithmetic: `ptr` is a 4-bit unsigned counter. There is no overflow flag; the wrap is silent.

## Timing
- Write latency is 1 cycle: data sampled at edge k appears on `outn` after edge k, and `strobe`/`frame_done` are high for exactly the cycle following edge k.
- Back-to-back `load` is accepted every cycle, with no stall and no ready signal.
- Reset values: all outputs 0, including `ptr`=0.
- Reset asserted mid-frame discards the partial shadow frame. The first auto write after reset targets channel 0.
- `sel`, `auto` and `in` are sampled only when `load`=1.

## Structure
- Package `demux16_pkg`:
  - `NUM_CH`=16, `SEL_W`=4.
  - typedef `ch_sel_t` (logic [3:0]).
  - typedef `ch_mask_t` (logic [15:0]).
- Sub-module `demux16_channel`, instantiated 16×:
  - contains the shadow and visible registers for one channel.
  - inputs: write-visible, write-shadow, publish, clear, data.
  - outputs: the value and a changed flag.
- The top level holds the pointer counter, the decode of `sel`/`ptr` into per-channel enables, the strobe mask and `frame_done`.

## Test plan
- Reset then manual write:
  - Stimulus: `rst_n`=0 for 2 cycles, then `load`=1, `auto`=0, `sel`=5, `in`=1.
  - Required: `out5`=1 and `strobe`=16'h0020 for one cycle; all other outputs stay 0; `ptr`=0.
- Buffered auto frame:
  - Stimulus: `BUFFERED`=1, `WIDTH`=4, 16 consecutive auto loads with `in`=channel index.
  - Required: outputs stay 0 for the first 15 loads. After the 16th load, `outn`=n, `strobe`=16'hFFFE (channel 0 is unchanged), `frame_done` pulses once, `ptr`=0.
- Unbuffered auto wrap:
  - Stimulus: `BUFFERED`=0, 17 auto loads of `in`=1.
  - Required: each load raises one strobe bit, walking from bit 0 to bit 15 and then bit 0 again; `frame_done` pulses once (after the 16th load); `ptr`=1 at the end.
- Clear versus load collision:
  - Stimulus: `ptr`=7 with outputs nonzero; apply `clear`=1 and `load`=1 in the same cycle.
  - Required: all outputs 0, `ptr`=0, `strobe`=0.
- Mode switch mid-frame:
  - Stimulus: 4 auto loads, then a manual write to channel 10 with `in`=1, then 12 auto loads with `in`=0.
  - Required: `out10` reads 1 after the manual write, and the publish overwrites it with the auto-frame value 0; `ptr` resumes at 4 after the switch back to auto.
- Reset mid-frame:
  - Stimulus: 8 buffered auto loads, then `rst_n`=0 for one cycle.
  - Required: `ptr`=0 and the shadow bank is cleared; a following full frame of `in`=0 produces `strobe`=0.
